// File: rtl/transpose_psum_accumulator.sv
// transpose_psum_accumulator
// Overlap-add accumulator for the transposed-convolution partial-sum stream.
// Each partial lands at buffer index base+col_id; base steps by STRIDE per
// tile. At layer end the buffer is drained as a valid/ready stream.
// Build option: define PSUM_SATURATE_EN to clamp drained values to the DW
// range; otherwise the drained value is the low DW bits of the accumulator.
module transpose_psum_accumulator #(
  parameter int DW      = 16,
  parameter int NUM_COL = 16,
  parameter int ACC_W   = 24,
  parameter int OUT_LEN = 64,
  parameter int STRIDE  = 2,
  localparam int CW     = $clog2(NUM_COL),
  localparam int IW     = $clog2(OUT_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tile_next,
  input  logic                 finish,
  input  logic                 psum_valid,
  input  logic [CW-1:0]        psum_col_id,
  input  logic signed [DW-1:0] psum_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [IW-1:0]        out_index,
  output logic                 busy,
  output logic                 overflow_err,
  output logic                 layer_done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ACCUM, S_DRAIN} state_t;

  state_t                   r_state;
  logic [IW:0]              r_base;
  logic [IW-1:0]            r_clr_ptr;
  logic [IW-1:0]            r_drain_ptr;
  logic                     r_ovf;
  logic                     r_done;
  logic signed [ACC_W-1:0]  r_mem [OUT_LEN];

  logic [IW:0]              w_idx;
  logic                     w_in_range;
  logic [IW+1:0]            w_base_sum;
  logic [IW:0]              w_base_nxt;
  logic signed [ACC_W-1:0]  w_psum_ext;
  logic                     w_we;
  logic [IW-1:0]            w_waddr;
  logic signed [ACC_W-1:0]  w_wdata;
  logic                     w_hs;
  logic                     w_last;

`ifdef PSUM_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [DW-1:0] conv(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      conv = SAT_MAX[DW-1:0];
    else if (a < SAT_MIN) conv = SAT_MIN[DW-1:0];
    else                  conv = a[DW-1:0];
  endfunction
`else
  function automatic logic signed [DW-1:0] conv(input logic signed [ACC_W-1:0] a);
    conv = a[DW-1:0];
  endfunction
`endif

  // Target index is computed one bit wider than the buffer so out-of-range
  // targets are detectable instead of aliasing onto low entries.
  assign w_idx      = r_base + (IW+1)'(psum_col_id);
  assign w_in_range = w_idx < (IW+1)'(OUT_LEN);
  assign w_psum_ext = ACC_W'(psum_data);

  // Base stops at OUT_LEN: any base at or past the end already drops every
  // partial, and pinning it there keeps base+col_id from wrapping back into
  // the valid range after many tiles.
  assign w_base_sum = {1'b0, r_base} + (IW+2)'(STRIDE);
  assign w_base_nxt = (w_base_sum >= (IW+2)'(OUT_LEN)) ? (IW+1)'(OUT_LEN)
                                                       : w_base_sum[IW:0];

  assign w_hs   = (r_state == S_DRAIN) && out_ready;
  assign w_last = r_drain_ptr == IW'(OUT_LEN-1);

  // Single buffer write port: clear sweep or read-modify-write accumulate.
  // The read is from the register array itself, so a partial in the cycle
  // after a write to the same entry already sees the updated value.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_ptr;
      end
      S_ACCUM: begin
        if (psum_valid && w_in_range) begin
          w_we    = 1'b1;
          w_waddr = w_idx[IW-1:0];
          w_wdata = r_mem[w_idx[IW-1:0]] + w_psum_ext;
        end
      end
      default: ;
    endcase
  end

  // Buffer storage; deliberately not reset, a new layer clears it explicitly.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Layer control FSM with its pointers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_clr_ptr   <= '0;
      r_drain_ptr <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_CLEAR;
            r_base    <= '0;
            r_clr_ptr <= '0;
            r_ovf     <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == IW'(OUT_LEN-1)) r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (psum_valid && !w_in_range) r_ovf <= 1'b1;
          if (tile_next) r_base <= w_base_nxt;
          if (finish) begin
            r_state     <= S_DRAIN;
            r_drain_ptr <= '0;
          end
        end
        S_DRAIN: begin
          if (w_hs) begin
            if (w_last) begin
              r_state     <= S_IDLE;
              r_drain_ptr <= '0;
              r_done      <= 1'b1;
            end else begin
              r_drain_ptr <= r_drain_ptr + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = (r_state == S_DRAIN);
  assign out_index    = r_drain_ptr;
  assign out_data     = out_valid ? conv(r_mem[r_drain_ptr]) : '0;
  assign busy         = (r_state != S_IDLE);
  assign overflow_err = r_ovf;
  assign layer_done   = r_done;

endmodule

// File: tb/tb_transpose_psum_accumulator.sv
// Bench for transpose_psum_accumulator: directed and random layers, reference
// buffer model, drain results checked by a queue-driven monitor.
module tb_transpose_psum_accumulator;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0, tile_next = 1'b0, finish = 1'b0;
  logic               psum_valid = 1'b0;
  logic [3:0]         psum_col_id = '0;
  logic signed [15:0] psum_data = '0;
  logic               out_ready = 1'b0;
  logic               out_valid, busy, overflow_err, layer_done;
  logic signed [15:0] out_data;
  logic [5:0]         out_index;

  transpose_psum_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tile_next(tile_next),
    .finish(finish), .psum_valid(psum_valid), .psum_col_id(psum_col_id),
    .psum_data(psum_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .busy(busy),
    .overflow_err(overflow_err), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; logic signed [15:0] data; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0;

  // reference model: plain 64-entry buffer of 24-bit wrapped sums
  logic signed [23:0] mdl [64];
  int m_base;
  bit m_ovf;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] ref_conv(input logic signed [23:0] a);
    int v;
    v = a;
`ifdef PSUM_SATURATE_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`endif
    return 16'(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_base = 0;
    m_ovf  = 1'b0;
    for (int i = 0; i < 64; i++) mdl[i] = '0;
    chk("start_busy", busy, 1);
    chk("start_ovf_clr", overflow_err, 0);
    repeat (70) tick();
  endtask

  // one ACCUM cycle; model follows the same inputs, finish queues the drain
  task automatic issue(input bit v, input int col, input int d, input bit tn, input bit fin);
    int idx;
    logic signed [15:0] d16;
    d16 = 16'(d);
    psum_valid  = v;
    psum_col_id = 4'(col);
    psum_data   = d16;
    tile_next   = tn;
    finish      = fin;
    if (v) begin
      idx = m_base + col;
      if (idx < 64) mdl[idx] = mdl[idx] + 24'(d16);
      else m_ovf = 1'b1;
    end
    if (tn) m_base += 2;
    if (fin) for (int i = 0; i < 64; i++) q.push_back('{i, ref_conv(mdl[i])});
    tick();
    psum_valid = 1'b0;
    tile_next  = 1'b0;
    finish     = 1'b0;
  endtask

  // mode 0: always ready, 1: random, 2: pattern 1,0,0,1
  task automatic drain(input int mode);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom % 2);
        default: out_ready = (k % 4 == 0) || (k % 4 == 3);
      endcase
      tick();
      k++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", k < 2000, 1);
    chk("drain_all_seen", q.size(), 0);
    chk("ovf_sticky", overflow_err, m_ovf);
    tick();
  endtask

  // monitor: pops the expected stream on every handshake, checks stalls hold
  bit stalled = 1'b0, exp_done = 1'b0;
  logic signed [15:0] p_data;
  logic [5:0] p_idx;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled  = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done) begin
        chk("done_pulse", layer_done, 1);
        chk("done_idle", busy, 0);
        chk("valid_drop", out_valid, 0);
        exp_done = 1'b0;
      end else begin
        chk("done_low", layer_done, 0);
      end
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, p_data);
        chk("hold_idx", out_index, p_idx);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: index %0d data %0d with nothing expected", out_index, out_data);
        end else begin
          e = q.pop_front();
          chk("out_index", out_index, e.idx);
          chk("out_data", out_data, e.data);
          if (e.idx == 63) exp_done = 1'b1;
        end
      end
      stalled = out_valid && !out_ready;
      p_data  = out_data;
      p_idx   = out_index;
    end
  end

  initial begin
    int k;
    // reset state
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_done", layer_done, 0);
    chk("rst_index", out_index, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // 1: empty layer drains all zeros in order
    do_start();
    issue(0, 0, 0, 0, 1);
    drain(0);

    // 2: back-to-back same index, tile step, coincident finish
    do_start();
    issue(1, 3, 100, 0, 0);
    issue(1, 3, -30, 0, 0);
    issue(0, 0, 0, 1, 0);
    issue(1, 1, 5, 0, 0);
    issue(1, 0, 11, 1, 1);
    drain(1);

    // 3: base 62, col 5 -> index 67 dropped, sticky error
    do_start();
    for (int i = 0; i < 31; i++) issue(0, 0, 0, 1, 0);
    issue(1, 5, 7, 0, 0);
    chk("ovf_set", overflow_err, 1);
    issue(1, 0, 9, 0, 0);
    chk("ovf_hold", overflow_err, 1);
    issue(0, 0, 0, 0, 1);
    drain(2);

    // 4: 400 x +100 at index 0 exceeds DW range
    do_start();
    for (int i = 0; i < 400; i++) issue(1, 0, 100, 0, 0);
    issue(0, 0, 0, 0, 1);
    drain(0);

    // accumulator wrap at ACC_W
    do_start();
    for (int i = 0; i < 300; i++) issue(1, 7, 32767, 0, 0);
    issue(1, 7, -32768, 0, 1);
    drain(1);

    // 5: stall pattern over a populated buffer
    do_start();
    for (int i = 0; i < 100; i++) issue(1, $urandom % 16, $urandom, (i % 8) == 7, 0);
    issue(0, 0, 0, 0, 1);
    drain(2);

    // random layers
    for (int l = 0; l < 4; l++) begin
      do_start();
      for (int i = 0; i < 150; i++)
        issue(($urandom % 4) != 0, $urandom % 16, $urandom,
              (($urandom % 12) == 0) && (m_base < 80), 0);
      issue($urandom % 2, $urandom % 16, $urandom, 0, 1);
      drain(1);
    end

    // 6: reset mid-drain at index 10, then a clean layer
    do_start();
    for (int i = 0; i < 20; i++) issue(1, $urandom % 16, $urandom, 0, 0);
    issue(0, 0, 0, 0, 1);
    out_ready = 1'b1;
    k = 0;
    while (!(out_valid && out_index == 6'd10) && k < 200) begin
      tick();
      k++;
    end
    chk("reach_idx10", k < 200, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", layer_done, 0);
    q.delete();
    out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_start();
    issue(0, 0, 0, 0, 1);
    drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
